invsqrt_wb_initiator: RTL and testbench
=======================================

INVSQRT_WB_INITIATOR -- requirements
Module: invsqrt_wb_initiator

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: Wishbone address driven for every write and read cycle.
REQ-002 Parameter RESULT_DELAY, default 8: idle cycles inserted between write completion and read start; legal range 0..255.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles to wait for ack_i per bus cycle; legal range 1..1023.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 s_data  input  16  Q12.4 operand from the upstream stream.
REQ-007 s_valid  input  1  operand valid.
REQ-008 s_ready  output  1  block can accept an operand.
REQ-009 m_data  output  16  result read back from the peripheral.
REQ-010 m_valid  output  1  result valid.
REQ-011 m_ready  input  1  downstream accepts the result.
REQ-012 adr_o  output  32  Wishbone address.
REQ-013 dat_o  output  16  Wishbone write data.
REQ-014 dat_i  input  16  Wishbone read data.
REQ-015 we_o  output  1  Wishbone write enable.
REQ-016 stb_o  output  1  Wishbone strobe.
REQ-017 cyc_o  output  1  Wishbone cycle.
REQ-018 ack_i  input  1  Wishbone acknowledge.
REQ-019 err_o  output  1  sticky timeout flag.
REQ-020 done_cnt  output  16  count of results delivered downstream.

Function
REQ-021 The FSM SHALL have states IDLE, WRITE, WAIT, READ and OUTPUT.
REQ-022 IDLE: s_ready SHALL be 1 only in IDLE; when s_valid && s_ready, s_data SHALL be latched and the next state SHALL be WRITE.
REQ-023 WRITE: cyc_o=stb_o=we_o=1, adr_o=BASE_ADDR and dat_o=latched operand, all registered and stable until ack_i.
REQ-024 On the first cycle in WRITE with ack_i=1, cyc_o/stb_o/we_o SHALL drop on the next edge and the FSM SHALL enter WAIT with the delay counter loaded with RESULT_DELAY.
REQ-025 WAIT: the counter SHALL decrement each cycle; at zero, the FSM SHALL enter READ. With RESULT_DELAY=0, exactly one WAIT cycle SHALL occur.
REQ-026 READ: cyc_o=stb_o=1, we_o=0, adr_o=BASE_ADDR; on ack_i=1, dat_i SHALL be captured into m_data, the bus SHALL be released on the next edge and the FSM SHALL enter OUTPUT.
REQ-027 OUTPUT: m_valid=1 with m_data held stable; on m_valid && m_ready, done_cnt SHALL increment (wrapping 16'hFFFF->0) and the FSM SHALL return to IDLE.
REQ-028 Minimum operand-to-m_valid latency with zero-wait ack SHALL be RESULT_DELAY+5 cycles.
REQ-029 A timeout counter SHALL clear on entry to WRITE or READ and increment while ack_i=0; on reaching TIMEOUT, the bus SHALL be released, err_o SHALL be set and the FSM SHALL go to IDLE, discarding the operand (no m_valid, no done_cnt change).
REQ-030 err_o SHALL remain 1 until reset; operation SHALL continue normally after a timeout.
REQ-031 ack_i SHALL be ignored when cyc_o=0 and in IDLE, WAIT and OUTPUT.
REQ-032 Only one bus cycle SHALL be outstanding at any time; cyc_o and stb_o SHALL always be equal.
REQ-033 dat_o SHALL hold its last value outside WRITE; adr_o SHALL be constant BASE_ADDR.

Reset
REQ-034 On rst=1, asynchronously: state=IDLE, cyc_o=stb_o=we_o=0, s_ready=0 while rst is high, m_valid=0, m_data=0, dat_o=0, adr_o=BASE_ADDR, err_o=0, done_cnt=0, and all counters=0.
REQ-035 Reset asserted mid-bus-cycle SHALL drop cyc_o/stb_o immediately, and the in-flight operand SHALL be lost.
REQ-036 s_ready SHALL be 1 on the first clock edge after rst deasserts.

Verification
REQ-037 Operand 16'h0040 (4.0), slave acks in 1 cycle and returns 16'h0008 -> one write with dat_o=0x0040, then RESULT_DELAY idle cycles, then one read; m_data=0x0008, m_valid held, done_cnt=1.
REQ-038 Slave delays ack by 3 cycles on write and on read -> cyc_o/stb_o/adr_o/dat_o remain stable throughout, latency extends by 6 cycles, and the result is correct.
REQ-039 Slave never acks, TIMEOUT=16 -> cyc_o drops after 16 cycles, err_o=1, no m_valid, and the next operand completes normally with err_o still 1.
REQ-040 m_ready held low for 10 cycles -> m_valid/m_data stable, s_ready=0 throughout, done_cnt increments once on release.
REQ-041 rst pulsed during READ -> cyc_o=0 in the same cycle, all outputs at their reset values, and a fresh operand afterwards completes normally.
REQ-042 Back-to-back stream of 4 operands with m_ready=1 -> 4 sequential write/read pairs with no overlap, done_cnt=4, and results in order.

Source files
------------

// File: rtl/invsqrt_wb_initiator_if.sv
// Stream and Wishbone signal bundle for the inverse-square-root initiator.
// master: the initiator's view; slave: the environment (upstream, downstream, peripheral).
interface invsqrt_wb_initiator_if;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] adr_o;
    logic [15:0] dat_o;
    logic [15:0] dat_i;
    logic        we_o;
    logic        stb_o;
    logic        cyc_o;
    logic        ack_i;

    modport master (
        input  s_data, s_valid, m_ready, dat_i, ack_i,
        output s_ready, m_data, m_valid, adr_o, dat_o, we_o, stb_o, cyc_o
    );

    modport slave (
        output s_data, s_valid, m_ready, dat_i, ack_i,
        input  s_ready, m_data, m_valid, adr_o, dat_o, we_o, stb_o, cyc_o
    );
endinterface

// File: rtl/invsqrt_wb_initiator.sv
// Wishbone initiator: takes a Q12.4 operand, writes it to the peripheral,
// waits RESULT_DELAY cycles, reads the result back and hands it downstream.
// Each bus cycle is guarded by a timeout that sets a sticky error flag.
module invsqrt_wb_initiator #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned RESULT_DELAY = 8,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    invsqrt_wb_initiator_if.master        bus,
    output logic                          err_o,
    output logic [15:0]                   done_cnt
);
    localparam logic [7:0] DLY_INIT = 8'(RESULT_DELAY);
    localparam logic [9:0] TO_LAST  = 10'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, WRITE, WAIT, READ, OUTPUT} state_t;

    state_t      state, state_nx;
    logic [7:0]  dly_cnt;
    logic [9:0]  to_cnt;
    logic        in_bus;
    logic        nx_bus;
    logic        ack_seen;
    logic        to_hit;
    logic        accept;

    assign in_bus   = (state == WRITE) || (state == READ);
    assign nx_bus   = (state_nx == WRITE) || (state_nx == READ);
    assign ack_seen = in_bus && bus.cyc_o && bus.ack_i;
    assign to_hit   = in_bus && !ack_seen && (to_cnt == TO_LAST);
    assign accept   = (state == IDLE) && bus.s_valid && bus.s_ready;
    assign bus.adr_o = BASE_ADDR;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode; a timeout abandons the operand and returns to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = WRITE;
            WRITE:   if (ack_seen) state_nx = WAIT;
                     else if (to_hit) state_nx = IDLE;
            WAIT:    if (dly_cnt == 8'd0) state_nx = READ;
            READ:    if (ack_seen) state_nx = OUTPUT;
                     else if (to_hit) state_nx = IDLE;
            OUTPUT:  if (bus.m_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Delay and timeout counters; the timeout restarts on each bus-cycle entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            if (state != WAIT && state_nx == WAIT)
                dly_cnt <= DLY_INIT;
            else if (state == WAIT && dly_cnt != 8'd0)
                dly_cnt <= dly_cnt - 8'd1;

            if (nx_bus && state_nx != state)
                to_cnt <= '0;
            else if (in_bus && !ack_seen)
                to_cnt <= to_cnt + 10'd1;
        end
    end

    // Registered outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.s_ready <= 1'b0;
            bus.cyc_o   <= 1'b0;
            bus.stb_o   <= 1'b0;
            bus.we_o    <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.dat_o   <= '0;
            bus.m_data  <= '0;
            err_o       <= 1'b0;
            done_cnt    <= '0;
        end else begin
            bus.s_ready <= (state_nx == IDLE);
            bus.cyc_o   <= nx_bus;
            bus.stb_o   <= nx_bus;
            bus.we_o    <= (state_nx == WRITE);
            bus.m_valid <= (state_nx == OUTPUT);
            if (accept)
                bus.dat_o <= bus.s_data;
            if (state == READ && ack_seen)
                bus.m_data <= bus.dat_i;
            if (to_hit)
                err_o <= 1'b1;
            if (state == OUTPUT && bus.m_valid && bus.m_ready)
                done_cnt <= done_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_invsqrt_wb_initiator.sv
// Directed bench for invsqrt_wb_initiator with a simple Wishbone peripheral model
// that returns 1/sqrt(x) in Q12.4 from a fixed lookup of the last written operand.
module tb_invsqrt_wb_initiator;
    localparam logic [31:0] BASE = 32'hA000_0010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err_o;
    logic [15:0] done_cnt;

    invsqrt_wb_initiator_if bus();

    invsqrt_wb_initiator #(
        .BASE_ADDR(BASE),
        .RESULT_DELAY(4),
        .TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .err_o(err_o),
        .done_cnt(done_cnt)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Peripheral model controls and observations.
    int          ack_wait = 0;
    logic        never_ack = 1'b0;
    int          slv_cnt;
    logic [15:0] mem;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic        expect_wr;
    int          order_viol = 0;
    int          stab_viol = 0;
    logic        prev_busy;
    logic [31:0] prev_adr;
    logic [15:0] prev_dat;
    logic        prev_we;

    function automatic logic [15:0] periph_resp(input logic [15:0] x);
        case (x)
            16'h0010: return 16'h0010;
            16'h0040: return 16'h0008;
            16'h0100: return 16'h0004;
            16'h0190: return 16'h0003;
            16'h0400: return 16'h0002;
            default:  return 16'hDEAD;
        endcase
    endfunction

    assign bus.dat_i = periph_resp(mem);

    // Peripheral: acks ack_wait cycles after the first registered-ack opportunity.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ack_i <= 1'b0;
            slv_cnt   <= 0;
            mem       <= '0;
            expect_wr <= 1'b1;
        end else begin
            if (bus.cyc_o && bus.stb_o && !bus.ack_i && !never_ack) begin
                if (slv_cnt == ack_wait) bus.ack_i <= 1'b1;
                else slv_cnt <= slv_cnt + 1;
            end else begin
                bus.ack_i <= 1'b0;
                slv_cnt   <= 0;
            end
            if (bus.cyc_o && bus.stb_o && bus.ack_i) begin
                if (bus.we_o) begin
                    wr_cnt <= wr_cnt + 1;
                    mem    <= bus.dat_o;
                    if (!expect_wr) order_viol <= order_viol + 1;
                    expect_wr <= 1'b0;
                end else begin
                    rd_cnt <= rd_cnt + 1;
                    if (expect_wr) order_viol <= order_viol + 1;
                    expect_wr <= 1'b1;
                end
            end
        end
    end

    // Bus-stability observer: a cycle still waiting for ack must not change.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_busy <= 1'b0;
        end else begin
            if (bus.cyc_o !== bus.stb_o) stab_viol <= stab_viol + 1;
            if (bus.adr_o !== BASE) stab_viol <= stab_viol + 1;
            if (prev_busy && bus.cyc_o &&
                (bus.adr_o !== prev_adr || bus.dat_o !== prev_dat || bus.we_o !== prev_we))
                stab_viol <= stab_viol + 1;
            prev_busy <= bus.cyc_o && !bus.ack_i;
            prev_adr  <= bus.adr_o;
            prev_dat  <= bus.dat_o;
            prev_we   <= bus.we_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operand and return once the accepting edge has passed.
    task automatic send(input logic [15:0] op, output logic ok);
        int n;
        n = 0;
        bus.s_data  = op;
        bus.s_valid = 1'b1;
        while (bus.s_ready !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        ok = (bus.s_ready === 1'b1);
        step();
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_mvalid(output int lat);
        lat = 0;
        while (bus.m_valid !== 1'b1 && lat < 60) begin
            step();
            lat++;
        end
    endtask

    initial begin : stim
        logic        ok;
        logic        seen_mv;
        int          lat;
        int          n;
        int          wr0;
        int          rd0;
        logic [15:0] ops [4];
        logic [15:0] res [4];

        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", bus.cyc_o, 1'b0);
        chk("rst_stb", bus.stb_o, 1'b0);
        chk("rst_we", bus.we_o, 1'b0);
        chk("rst_s_ready", bus.s_ready, 1'b0);
        chk("rst_m_valid", bus.m_valid, 1'b0);
        chk("rst_m_data", bus.m_data, 16'h0000);
        chk("rst_dat_o", bus.dat_o, 16'h0000);
        chk("rst_adr", bus.adr_o, BASE);
        chk("rst_err", err_o, 1'b0);
        chk("rst_done", done_cnt, 16'h0000);
        rst = 1'b0;
        step();
        chk("s_ready_after_rst", bus.s_ready, 1'b1);

        // 4.0 -> 0.5, single-cycle ack, then downstream stalled for 10 cycles.
        send(16'h0040, ok);
        chk("t1_accept", ok, 1'b1);
        chk("t1_cyc", bus.cyc_o, 1'b1);
        chk("t1_we", bus.we_o, 1'b1);
        chk("t1_dat_o", bus.dat_o, 16'h0040);
        wait_mvalid(lat);
        chk("t1_latency", lat, 9);
        chk("t1_m_data", bus.m_data, 16'h0008);
        chk("t1_writes", wr_cnt, 1);
        chk("t1_reads", rd_cnt, 1);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.m_valid !== 1'b1 || bus.m_data !== 16'h0008 ||
                bus.s_ready !== 1'b0 || done_cnt !== 16'h0000) ok = 1'b0;
        end
        chk("t1_hold_stable", ok, 1'b1);
        bus.m_ready = 1'b1;
        step();
        chk("t1_done", done_cnt, 16'h0001);
        chk("t1_m_valid_drop", bus.m_valid, 1'b0);
        chk("t1_s_ready_back", bus.s_ready, 1'b1);

        // Three extra wait states on both write and read.
        ack_wait = 3;
        send(16'h0100, ok);
        wait_mvalid(lat);
        chk("t2_latency", lat, 15);
        chk("t2_m_data", bus.m_data, 16'h0004);
        step();
        chk("t2_done", done_cnt, 16'h0002);
        chk("t2_err", err_o, 1'b0);
        chk("t2_stable", stab_viol, 0);
        ack_wait = 0;

        // Peripheral never acks: timeout after 16 cycles, operand discarded.
        never_ack = 1'b1;
        wr0 = wr_cnt;
        send(16'h0010, ok);
        n = 0;
        seen_mv = 1'b0;
        do begin
            step();
            n++;
            if (bus.m_valid === 1'b1) seen_mv = 1'b1;
        end while (bus.cyc_o === 1'b1 && n < 40);
        chk("t3_cyc_cycles", n, 16);
        chk("t3_err", err_o, 1'b1);
        chk("t3_no_m_valid", seen_mv, 1'b0);
        chk("t3_done_kept", done_cnt, 16'h0002);
        chk("t3_s_ready", bus.s_ready, 1'b1);
        chk("t3_no_write", wr_cnt, wr0);
        never_ack = 1'b0;
        send(16'h0190, ok);
        wait_mvalid(lat);
        chk("t3_next_latency", lat, 9);
        chk("t3_next_m_data", bus.m_data, 16'h0003);
        step();
        chk("t3_next_done", done_cnt, 16'h0003);
        chk("t3_err_sticky", err_o, 1'b1);

        // Reset pulsed in the middle of a read cycle.
        ack_wait = 3;
        send(16'h0400, ok);
        n = 0;
        while (!(bus.cyc_o === 1'b1 && bus.we_o === 1'b0) && n < 60) begin
            step();
            n++;
        end
        chk("t4_in_read", bus.cyc_o & ~bus.we_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t4_cyc", bus.cyc_o, 1'b0);
        chk("t4_stb", bus.stb_o, 1'b0);
        chk("t4_s_ready", bus.s_ready, 1'b0);
        chk("t4_m_valid", bus.m_valid, 1'b0);
        chk("t4_m_data", bus.m_data, 16'h0000);
        chk("t4_dat_o", bus.dat_o, 16'h0000);
        chk("t4_err", err_o, 1'b0);
        chk("t4_done", done_cnt, 16'h0000);
        step();
        rst = 1'b0;
        ack_wait = 0;
        step();
        chk("t4_s_ready_after", bus.s_ready, 1'b1);
        send(16'h0040, ok);
        wait_mvalid(lat);
        chk("t4_fresh_latency", lat, 9);
        chk("t4_fresh_m_data", bus.m_data, 16'h0008);
        step();
        chk("t4_fresh_done", done_cnt, 16'h0001);

        // Back-to-back stream of four operands.
        ops[0] = 16'h0010; res[0] = 16'h0010;
        ops[1] = 16'h0040; res[1] = 16'h0008;
        ops[2] = 16'h0100; res[2] = 16'h0004;
        ops[3] = 16'h0400; res[3] = 16'h0002;
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        for (int i = 0; i < 4; i++) begin
            send(ops[i], ok);
            wait_mvalid(lat);
            chk($sformatf("t5_m_data_%0d", i), bus.m_data, res[i]);
            step();
        end
        chk("t5_done", done_cnt, 16'h0005);
        chk("t5_writes", wr_cnt - wr0, 4);
        chk("t5_reads", rd_cnt - rd0, 4);
        chk("order", order_viol, 0);
        chk("stability", stab_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
